dsp_fir_filter: RTL and testbench

Parametrised, programmable N-tap FIR filter with a valid/ready stream interface, for the DSP datapath. It supports three modes: bypass, moving average, and programmable-coefficient FIR. A single time-multiplexed multiply-accumulate unit iterates over the taps, so each sample costs TAPS+1 cycles. Coefficients are written through a register-style port.

---
 rtl/dsp_fir_pkg.sv | 35 +++
 rtl/dsp_fir_mac.sv | 40 ++++
 rtl/dsp_fir_filter.sv | 138 +++++++++++++
 tb/tb_dsp_fir_filter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter: mode encodings,
// FSM state type, accumulator sizing and output saturation helper.
package dsp_fir_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_AVG    = 2'b01;
    localparam logic [1:0] MODE_FIR    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    // Working width for the saturation helper; must exceed any ACC_W in use.
    localparam int SAT_W = 128;

    // Accumulator width that can hold TAPS full-scale products without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a sign-extended value to the signed range of a w-bit result.
    function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                          input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = {1'b0, {(SAT_W-1){1'b1}}} >>> (SAT_W - w);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dsp_fir_mac.sv
// Signed multiply-accumulate unit: one product per enabled cycle, added
// (sign-extended) into an ACC_W accumulator. clr has priority over en.
module dsp_fir_mac #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 51
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic signed [COEF_W-1:0] i_coef,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  r_acc;

    // Full-precision signed product of the current tap and coefficient.
    always_comb begin
        w_prod = PROD_W'(i_sample) * PROD_W'(i_coef);
    end

    // Accumulator register with synchronous clear and enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dsp_fir_filter.sv
// Programmable N-tap FIR filter (bypass / moving average / FIR) with a
// single time-multiplexed MAC and valid/ready streaming ports.
// Optional macro DSP_SAT_EN: saturate averaged/FIR results instead of wrapping.
module dsp_fir_filter
    import dsp_fir_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int COEF_W     = 16,
    parameter int TAPS       = 8,
    parameter int COEF_SHIFT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    output logic                      coef_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      busy
);

    localparam int            AW       = $clog2(TAPS);
    localparam int            ACC_W    = acc_width(DATA_W, COEF_W, TAPS);
    localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [DATA_W-1:0] r_taps [TAPS];
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic [1:0]               r_mode;
    logic [AW-1:0]            r_idx;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_coef_err;

    logic                     w_accept;
    logic                     w_bypass_in;
    logic                     w_use_acc;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [DATA_W-1:0] w_result;

    assign w_accept    = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_bypass_in = (mode != MODE_AVG) && (mode != MODE_FIR);
    assign w_use_acc   = (r_mode == MODE_AVG) || (r_mode == MODE_FIR);
    assign w_coef      = (r_mode == MODE_FIR) ? r_coef[r_idx] : COEF_W'(1);

    dsp_fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_accept || flush),
        .i_en     ((r_state == ST_MAC) && !flush),
        .i_sample (r_taps[r_idx]),
        .i_coef   (w_coef),
        .o_acc    (w_acc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; flush forces IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_bypass_in ? ST_OUT : ST_MAC;
            ST_MAC:  if (r_idx == IDX_LAST) w_state_next = ST_OUT;
            ST_OUT:  if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) w_state_next = ST_IDLE;
    end

    // Result formation: arithmetic shift, then wrap or saturate to DATA_W.
    always_comb begin
        w_shifted = (r_mode == MODE_FIR) ? (w_acc >>> COEF_SHIFT) : (w_acc >>> AW);
`ifdef DSP_SAT_EN
        w_result  = DATA_W'(sat_clamp(SAT_W'(w_shifted), DATA_W));
`else
        w_result  = w_shifted[DATA_W-1:0];
`endif
    end

    // Coefficient RAM; writes land only in IDLE, otherwise flag a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < TAPS; k++) r_coef[k] <= '0;
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= coef_we && (r_state != ST_IDLE);
            if (coef_we && (r_state == ST_IDLE)) r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Delay line, latched mode, tap index and bypass output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < TAPS; k++) r_taps[k] <= '0;
            r_mode     <= MODE_BYPASS;
            r_idx      <= '0;
            r_out_data <= '0;
        end else if (flush) begin
            for (int unsigned k = 0; k < TAPS; k++) r_taps[k] <= '0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_taps[0] <= in_data;
                for (int unsigned k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
                r_mode <= mode;
                r_idx  <= '0;
                if (w_bypass_in) r_out_data <= in_data;
            end
            if (r_state == ST_MAC) r_idx <= r_idx + AW'(1);
        end
    end

    // Filtered results are formed directly from the held accumulator, which
    // is final on entry to OUT and stays frozen there; bypass uses the register.
    assign out_data  = w_use_acc ? w_result : r_out_data;
    assign out_valid = (r_state == ST_OUT);
    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign coef_err  = r_coef_err;

endmodule

// File: tb/tb_dsp_fir_filter.sv
// Directed self-checking bench for dsp_fir_filter (TAPS=4): a 32-bit
// instance for the main scenarios and a 16-bit instance for wrap/saturate.
module tb_dsp_fir_filter;

    localparam int TAPS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // 32-bit instance signals
    logic [1:0]         mode = 2'b00;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_data = '0;
    logic               coef_we = 1'b0;
    logic [1:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_err;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] out_data;
    logic               busy;

    // 16-bit instance signals
    logic               b_in_valid = 1'b0;
    logic               b_in_ready;
    logic signed [15:0] b_in_data = '0;
    logic               b_coef_we = 1'b0;
    logic [1:0]         b_coef_addr = '0;
    logic signed [15:0] b_coef_wdata = '0;
    logic               b_coef_err;
    logic               b_out_valid;
    logic               b_out_ready = 1'b0;
    logic signed [15:0] b_out_data;
    logic               b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsp_fir_filter #(
        .DATA_W     (32),
        .COEF_W     (16),
        .TAPS       (TAPS),
        .COEF_SHIFT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    dsp_fir_filter #(
        .DATA_W     (16),
        .COEF_W     (16),
        .TAPS       (TAPS),
        .COEF_SHIFT (15)
    ) dut16 (
        .clk        (clk),
        .reset      (reset),
        .mode       (2'b10),
        .flush      (1'b0),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .coef_we    (b_coef_we),
        .coef_addr  (b_coef_addr),
        .coef_wdata (b_coef_wdata),
        .coef_err   (b_coef_err),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .busy       (b_busy)
    );

    // ---------------- stimulus helpers (no checking) ----------------

    task automatic write_coef(input logic [1:0] a, input logic signed [15:0] v);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // Present one sample (optionally with a same-cycle coefficient write);
    // returns 1 ns after the acceptance edge.
    task automatic accept(input logic [1:0] m, input logic signed [31:0] d,
                          input logic cw, input logic [1:0] ca, input logic signed [15:0] cd);
        @(negedge clk);
        mode = m; in_data = d; in_valid = 1'b1;
        coef_we = cw; coef_addr = ca; coef_wdata = cd;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts cycles after acceptance.
    task automatic wait_out(input logic consume, output logic signed [31:0] q, output int lat);
        lat = 0;
        q   = 'x;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin
                lat = k;
                q   = out_data;
                break;
            end
            @(posedge clk); #1;
        end
        if (consume && lat != 0) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic xfer(input logic [1:0] m, input logic signed [31:0] d,
                        output logic signed [31:0] q, output int lat);
        accept(m, d, 1'b0, 2'd0, 16'sd0);
        wait_out(1'b1, q, lat);
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset;
        reset = 1'b1;
        #12;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || coef_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got valid=%b busy=%b err=%b exp=0/0/0", out_valid, busy, coef_err);
        end
        n_checks++;
        if (out_data !== 32'sd0) begin n_fail++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_average;
        logic signed [31:0] ins [4] = '{32'sd4, 32'sd8, 32'sd12, 32'sd16};
        logic signed [31:0] exp [4] = '{32'sd1, 32'sd3, 32'sd6, 32'sd10};
        logic signed [31:0] q;
        int lat;
        for (int i = 0; i < 4; i++) begin
            xfer(2'b01, ins[i], q, lat);
            n_checks++;
            if (q !== exp[i]) begin n_fail++; $display("FAIL avg_data[%0d] got=%0d exp=%0d", i, q, exp[i]); end
            n_checks++;
            if (lat != TAPS + 1) begin n_fail++; $display("FAIL avg_latency[%0d] got=%0d exp=%0d", i, lat, TAPS + 1); end
        end
    endtask

    task automatic test_fir;
        logic signed [31:0] q;
        int lat;
        write_coef(2'd0, 16'sh4000);
        xfer(2'b10, 32'sd100, q, lat);
        n_checks++;
        if (q !== 32'sd50) begin n_fail++; $display("FAIL fir_first got=%0d exp=50", q); end
        n_checks++;
        if (lat != TAPS + 1) begin n_fail++; $display("FAIL fir_latency got=%0d exp=%0d", lat, TAPS + 1); end
        write_coef(2'd1, 16'sh4000);
        xfer(2'b10, 32'sd200, q, lat);
        n_checks++;
        if (q !== 32'sd150) begin n_fail++; $display("FAIL fir_second got=%0d exp=150", q); end
    endtask

    task automatic test_backpressure;
        logic signed [31:0] q;
        int lat;
        // delay line becomes 40,200,100,16 -> 356/4
        accept(2'b01, 32'sd40, 1'b0, 2'd0, 16'sd0);
        wait_out(1'b0, q, lat);
        n_checks++;
        if (q !== 32'sd89) begin n_fail++; $display("FAIL hold_first got=%0d exp=89", q); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'sd999; mode = 2'b01;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'sd89 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d] got valid=%b data=%0d rdy=%b exp 1/89/0", c, out_valid, out_data, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release got rdy=%b valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_coef_err;
        logic signed [31:0] q;
        int lat;
        // delay line 0,40,200,100; only c0=c1=0.5 -> 20 unless c2 gets corrupted
        accept(2'b10, 32'sd0, 1'b0, 2'd0, 16'sd0);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 16'sh7FFF;
        @(posedge clk); #1;
        coef_we = 1'b0;
        n_checks++;
        if (coef_err !== 1'b1) begin n_fail++; $display("FAIL coef_err_pulse got=%b exp=1", coef_err); end
        @(posedge clk); #1;
        n_checks++;
        if (coef_err !== 1'b0) begin n_fail++; $display("FAIL coef_err_single got=%b exp=0", coef_err); end
        wait_out(1'b1, q, lat);
        n_checks++;
        if (q !== 32'sd20) begin n_fail++; $display("FAIL coef_err_unchanged got=%0d exp=20", q); end
    endtask

    task automatic test_flush;
        logic signed [31:0] q;
        int lat;
        bit seen;
        accept(2'b01, 32'sd1000, 1'b0, 2'd0, 16'sd0);
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle got busy=%b rdy=%b exp 0/1", busy, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL flush_no_output got valid=1 exp=0"); end
        xfer(2'b01, 32'sd8, q, lat);
        n_checks++;
        if (q !== 32'sd2) begin n_fail++; $display("FAIL flush_cleared_line got=%0d exp=2", q); end
    endtask

    task automatic test_bypass_negative;
        logic signed [31:0] q;
        int lat;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        xfer(2'b01, -32'sd7, q, lat);
        n_checks++;
        if (q !== -32'sd2) begin n_fail++; $display("FAIL avg_negative got=%0d exp=-2", q); end
        xfer(2'b00, 32'shDEADBEEF, q, lat);
        n_checks++;
        if (q !== 32'shDEADBEEF) begin n_fail++; $display("FAIL bypass_data got=%h exp=deadbeef", q); end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL bypass_latency got=%0d exp=1", lat); end
        // coefficients were cleared by reset
        xfer(2'b10, 32'sd123, q, lat);
        n_checks++;
        if (q !== 32'sd0) begin n_fail++; $display("FAIL fir_zero_coefs got=%0d exp=0", q); end
        xfer(2'b11, 32'sd77, q, lat);
        n_checks++;
        if (q !== 32'sd77 || lat != 1) begin n_fail++; $display("FAIL reserved_mode got=%0d lat=%0d exp=77 lat=1", q, lat); end
    endtask

    task automatic test_simultaneous;
        logic signed [31:0] q;
        int lat;
        // coef0 = -1.0 written on the acceptance edge
        accept(2'b10, 32'sd64, 1'b1, 2'd0, 16'sh8000);
        wait_out(1'b1, q, lat);
        n_checks++;
        if (q !== -32'sd64) begin n_fail++; $display("FAIL simult_coef got=%0d exp=-64", q); end
    endtask

    task automatic test_saturation;
        logic signed [15:0] res [4];
        logic signed [15:0] exp4;
`ifdef DSP_SAT_EN
        exp4 = 16'sh7FFF;
`else
        exp4 = 16'shFFF8;
`endif
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            b_coef_we = 1'b1; b_coef_addr = 2'(a); b_coef_wdata = 16'sh7FFF;
            @(posedge clk); #1;
            b_coef_we = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = 16'sd32767;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            res[i] = 'x;
            for (int k = 0; k < 20; k++) begin
                if (b_out_valid) begin res[i] = b_out_data; break; end
                @(posedge clk); #1;
            end
            @(negedge clk);
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
        n_checks++;
        if (res[0] !== 16'sd32766) begin n_fail++; $display("FAIL sat16_first got=%0d exp=32766", res[0]); end
        n_checks++;
        if (res[3] !== exp4) begin n_fail++; $display("FAIL sat16_fourth got=%0d exp=%0d", res[3], exp4); end
    endtask

    task automatic test_async_reset;
        accept(2'b00, 32'sd55, 1'b0, 2'd0, 16'sd0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got=%b exp=1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'sd0) begin
            n_fail++; $display("FAIL areset_immediate got valid=%b busy=%b data=%0d exp 0/0/0", out_valid, busy, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_average();
        test_fir();
        test_backpressure();
        test_coef_err();
        test_flush();
        test_bypass_negative();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
